fifo_param: RTL
===============

// Module: fifo_param
// PURPOSE
//  Parametrised single-clock FIFO: configurable data width and depth (any depth >= 2, not just 2^n).
//  Selectable overflow policy. Almost-full/almost-empty thresholds. Sticky overflow/underflow error
//  flags and a synchronous flush. Drop-in buffer between streaming producers and consumers; async read.
// PARAMETERS
//  DATA_W     8         data word width, bits
//  DEPTH      16        number of entries, >= 2, need not be a power of two
//  AW         $clog2(DEPTH)  pointer width (derived, do not override)
//  AFULL_TH   DEPTH-2   almost_full asserts when count >= AFULL_TH
//  AEMPTY_TH  2         almost_empty asserts when count <= AEMPTY_TH
//  OVERWRITE  1         1: write while full overwrites oldest; 0: write while full is dropped
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       reset, asynchronous, active-high
//  flush         in   1       sync clear of pointers/count; sticky flags unaffected
//  wen           in   1       write request
//  wdata         in   DATA_W  write data
//  ren           in   1       read request (pop)
//  rdata         out  DATA_W  head-of-queue data, combinational from mem[raddr]
//  count         out  AW+1    occupancy, 0..DEPTH
//  full, empty   out  1       count==DEPTH / count==0
//  almost_full   out  1       count >= AFULL_TH
//  almost_empty  out  1       count <= AEMPTY_TH
//  overflow      out  1       sticky: write attempted while full
//  underflow     out  1       sticky: pop attempted while empty
//  clr_err       in   1       sync clear of overflow/underflow
// BEHAVIOUR
//  Reset (async): waddr=raddr=0, count=0, overflow=underflow=0. Memory not reset.
//  While rst high: full, empty, almost_full, almost_empty all forced 0. rdata don't-care.
//  First edge after rst falls: empty=1, almost_empty=1.
//  Pointers: increment by 1, wrap DEPTH-1 -> 0. Never reach >= DEPTH.
//  Write: mem[waddr] <= wdata on edge. Visible on rdata the cycle after (zero read latency once stored).
//  Priority per edge: flush > normal operation.
//  flush: waddr=raddr=0, count=0. wen/ren ignored that cycle.
//  Case table (count = c at edge):
//    wen & !ren, c<DEPTH  : write, waddr++, c+1
//    wen & !ren, c==DEPTH : OVERWRITE=1 -> write, waddr++, raddr++, c stays DEPTH, overflow<=1
//                           OVERWRITE=0 -> no write, no pointer move, overflow<=1
//    !wen & ren, c>0      : raddr++, c-1
//    !wen & ren, c==0     : no pointer move, underflow<=1. rdata is stale, not valid
//    wen & ren,  c>0      : write + pop, both pointers ++, c unchanged (also valid at c==DEPTH)
//    wen & ren,  c==0     : write only, waddr++, c=1, underflow<=1
//  Invariant: count == (waddr - raddr) mod DEPTH, except count==DEPTH when waddr==raddr.
//  Count changes by at most 1 per cycle.
//  clr_err clears both sticky flags. A new error event in the same cycle wins, so the flag stays 1.
//  Thresholds: AEMPTY_TH < AFULL_TH <= DEPTH. Other settings are illegal (elaboration assertion).
//  Formal (`ifdef FORMAL): assert count<=DEPTH, the pointer invariant, full/empty consistency,
//   outputs zero under rst. Cover full, overwrite, underflow, and wrap of a non-2^n DEPTH.
// TESTING
//  T1 DEPTH=16: write 0x01..0x10, then pop 16 -> rdata 0x01..0x10 in order; full at 16, empty after.
//  T2 OVERWRITE=1, full with 0x01..0x10, write 0xAA -> count=16, overflow=1, rdata=0x02.
//     Last pop returns 0xAA.
//  T3 OVERWRITE=0, full, write 0xAA -> count=16, overflow=1, contents 0x01..0x10 unchanged.
//  T4 DEPTH=5: 12 write/pop pairs with count at 2 -> pointers wrap 4->0, data in order, count stays 2.
//  T5 empty, wen&ren with 0x55 -> count=1, underflow=1, rdata=0x55; clr_err next cycle -> underflow=0.
//  T6 count=7, assert rst mid-burst -> count=0 and flags 0 immediately; status 0 while rst high.
//     flush at count=3 -> count=0, sticky flags preserved.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO, any DEPTH >= 2.
// Selectable overflow policy, thresholds, sticky error flags.
module fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int OVERWRITE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AE_C  = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0]   ONE   = (AW+1)'(1);
  localparam bit            OVW   = (OVERWRITE != 0);

  if (DEPTH < 2 || AW != $clog2(DEPTH) ||
      AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH ||
      AEMPTY_TH < 0) begin : g_bad_params
    $error("fifo_param: illegal DEPTH/AW/threshold setting");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_waddr;
  logic [AW-1:0]     r_raddr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_we;
  logic w_pop;
  logic w_ovf_evt;
  logic w_udf_evt;

  function automatic logic [AW-1:0] f_inc(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == FULLC);
  assign w_empty = (r_count == '0);

  // A write at full only lands if a pop frees the slot
  // or the oldest entry may be overwritten.
  assign w_we = !rst && !flush && wen &&
                (!w_full || ren || OVW);

  // Overwrite at full drags the read pointer along.
  assign w_pop = !flush &&
                 ((ren && !w_empty) ||
                  (OVW && wen && !ren && w_full));

  assign w_ovf_evt = !flush && wen && !ren && w_full;
  assign w_udf_evt = !flush && ren && w_empty;

  // Storage: no reset, written only on accepted writes.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_waddr] <= wdata;
  end

  // Pointers and occupancy; flush beats normal operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else begin
      if (w_we) r_waddr <= f_inc(r_waddr);
      if (w_pop) r_raddr <= f_inc(r_raddr);
      if (w_we && !w_pop)
        r_count <= r_count + ONE;
      else if (w_pop && !w_we)
        r_count <= r_count - ONE;
    end
  end

  // Sticky error flags; a fresh event outranks clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_udf_evt)    r_udf <= 1'b1;
      else if (clr_err) r_udf <= 1'b0;
    end
  end

  assign rdata        = r_mem[r_raddr];
  assign count        = r_count;
  assign full         = !rst && w_full;
  assign empty        = !rst && w_empty;
  assign almost_full  = !rst && (r_count >= AF_C);
  assign almost_empty = !rst && (r_count <= AE_C);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

`ifdef FORMAL
  logic [AW:0] f_diff;
  always_comb begin
    f_diff = '0;
    if (r_waddr >= r_raddr)
      f_diff = (AW+1)'(r_waddr) - (AW+1)'(r_raddr);
    else
      f_diff = (AW+1)'(r_waddr) + FULLC -
               (AW+1)'(r_raddr);
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (!full && !empty);
      assert (!almost_full && !almost_empty);
    end else begin
      assert (r_count <= FULLC);
      assert (r_waddr <= LAST && r_raddr <= LAST);
      if (f_diff == '0)
        assert (r_count == '0 || r_count == FULLC);
      else
        assert (r_count == f_diff);
      assert (full == (r_count == FULLC));
      assert (empty == (r_count == '0));
      cover (full);
      cover (w_pop && w_we && w_full && !ren);
      cover (w_udf_evt);
      cover (((DEPTH & (DEPTH - 1)) != 0) &&
             w_we && r_waddr == LAST);
    end
  end
`endif

endmodule
